cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute/memory/writeback controller for the single-cycle-less CPU datapath: RAM, register bank, memory control and master ALU.
- Replaces hand-driven RAM addressing with a program counter and a state machine.
- Owns the PC, the instruction register, the NZCV flag register and all enable strobes.
- ALU and register bank remain combinational and are fed from the latched instruction fields.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cond_check.sv | 47 ++++
 rtl/cpu_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU sequencer: FSM state encoding, opcode and
// condition-code constants, instruction field positions and flag bit indices.
// No ports; imported by cpu_sequencer and cond_check.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Opcodes that change the sequencing; every other value is a plain ALU op
    localparam logic [3:0] OPC_CMP  = 4'b1010;
    localparam logic [3:0] OPC_LDR  = 4'b1101;
    localparam logic [3:0] OPC_STR  = 4'b1110;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Instruction field bit positions
    localparam int COND_MSB   = 31;
    localparam int COND_LSB   = 28;
    localparam int OPC_MSB    = 27;
    localparam int OPC_LSB    = 24;
    localparam int S_BIT      = 23;
    localparam int DEST_MSB   = 22;
    localparam int DEST_LSB   = 19;
    localparam int SRC2_MSB   = 18;
    localparam int SRC2_LSB   = 15;
    localparam int SRC1_MSB   = 14;
    localparam int SRC1_LSB   = 11;
    localparam int SHIFT_MSB  = 10;
    localparam int SHIFT_LSB  = 6;
    localparam int IVMOV_MSB  = 18;
    localparam int IVMOV_LSB  = 3;

    // Flag bit indices inside the 4-bit NZCV register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for opcodes that need the MEM state
    function automatic logic is_mem_op(input logic [3:0] opc);
        return (opc == OPC_LDR) || (opc == OPC_STR);
    endfunction

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Combinational condition-code evaluator.
// Ports:
//   i_cond  [3:0]  condition field of the latched instruction
//   i_flags [3:0]  architectural NZCV register
//   o_pass         1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle fetch/decode/execute/memory/writeback controller. Owns the PC,
// instruction register, NZCV flags and every enable strobe; the ALU and the
// register bank stay combinational and are fed from the latched instruction.
// Ports:
//   Clk, Reset       clock; synchronous active-low reset
//   start            one-cycle pulse, leaves IDLE/HALT and fetches at RESET_PC
//   mem_en/rw/addr   RAM request (rw 1=read), held until mem_ack
//   mem_wdata        store data for STR
//   mem_rdata/ack    RAM response; ack may come in the request cycle
//   instr            latched instruction register
//   alu_result/flags combinational ALU outputs for the current instr
//   src2_data        register-bank value of the src2 field (STR data)
//   flags            architectural NZCV register
//   rf_we/rf_wdata   one-cycle register-bank write strobe and data
//   pc               program counter
//   busy, halted     status
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       instr,
    input  logic [31:0]       alu_result,
    input  logic [3:0]        alu_flags,
    input  logic [31:0]       src2_data,
    output logic [3:0]        flags,
    output logic              rf_we,
    output logic [31:0]       rf_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_instr;
    logic [3:0]          r_flags;
    logic                r_mem_en;
    logic                r_mem_rw;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_rf_we;
    logic [31:0]         r_rf_wdata;
    logic                r_busy;
    logic                r_halted;

    logic                w_cond_pass;
    logic [3:0]          w_opc;
    logic                w_s;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_res_addr;

    assign w_opc      = r_instr[OPC_MSB:OPC_LSB];
    assign w_s        = r_instr[S_BIT];
    // Natural modulo-2^ADDR_W wrap; no overflow handling is wanted
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_res_addr = alu_result[ADDR_W-1:0];

    cond_check u_cond (
        .i_cond  (r_instr[COND_MSB:COND_LSB]),
        .i_flags (r_flags),
        .o_pass  (w_cond_pass)
    );

    // Outputs are registered: each transition loads the values the next
    // state must present, so the RAM request is already on the bus in the
    // first FETCH/MEM cycle and zero-wait acks complete in that cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= PC_RST;
            r_instr     <= '0;
            r_flags     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rf_we     <= 1'b0;
            r_rf_wdata  <= '0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_pc       <= PC_RST;
                        r_flags    <= '0;
                        r_mem_en   <= 1'b1;
                        r_mem_rw   <= 1'b1;
                        r_mem_addr <= PC_RST;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (mem_ack) begin
                        r_instr  <= mem_rdata;
                        r_mem_en <= 1'b0;
                        r_state  <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    // HALT is decided before the condition: it stops
                    // regardless of flags and leaves pc on itself.
                    if (w_opc == OPC_HALT) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (!w_cond_pass) begin
                        r_pc       <= w_pc_inc;
                        r_state    <= ST_FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_rw   <= 1'b1;
                        r_mem_addr <= w_pc_inc;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_rf_wdata <= alu_result;
                    if (w_s) begin
                        r_flags <= alu_flags;
                    end
                    if (is_mem_op(w_opc)) begin
                        r_state    <= ST_MEM;
                        r_mem_en   <= 1'b1;
                        r_mem_rw   <= (w_opc == OPC_LDR);
                        r_mem_addr <= w_res_addr;
                        if (w_opc == OPC_STR) begin
                            r_mem_wdata <= src2_data;
                        end
                    end else if (w_opc == OPC_CMP) begin
                        r_pc       <= w_pc_inc;
                        r_state    <= ST_FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_rw   <= 1'b1;
                        r_mem_addr <= w_pc_inc;
                    end else begin
                        r_state <= ST_WB;
                        r_rf_we <= 1'b1;
                    end
                end

                ST_MEM: begin
                    if (mem_ack) begin
                        if (w_opc == OPC_STR) begin
                            // Go straight to the next fetch; mem_en stays up
                            r_pc       <= w_pc_inc;
                            r_state    <= ST_FETCH;
                            r_mem_rw   <= 1'b1;
                            r_mem_addr <= w_pc_inc;
                        end else begin
                            r_rf_wdata <= mem_rdata;
                            r_rf_we    <= 1'b1;
                            r_mem_en   <= 1'b0;
                            r_state    <= ST_WB;
                        end
                    end
                end

                ST_WB: begin
                    r_pc       <= w_pc_inc;
                    r_state    <= ST_FETCH;
                    r_mem_en   <= 1'b1;
                    r_mem_rw   <= 1'b1;
                    r_mem_addr <= w_pc_inc;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign instr     = r_instr;
    assign flags     = r_flags;
    assign rf_we     = r_rf_we;
    assign rf_wdata  = r_rf_wdata;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Drives cpu_sequencer (ADDR_W=4) with a bench RAM that acks after a
// programmable number of wait cycles and a stub ALU computed from instr.
// Expected behaviour comes from an instruction-level model that walks the
// program and predicts every fetch/load read, store request cycle, register
// write, the halt cycle and the final pc/flags.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int AW = 4;
    localparam logic [31:0] HALT_W = 32'hEF00_0000;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic          mem_en, mem_rw, mem_ack, rf_we, busy, halted;
    logic [AW-1:0] mem_addr, pc;
    logic [31:0]   mem_wdata, mem_rdata, instr, alu_result, src2_data, rf_wdata;
    logic [3:0]    alu_flags, flags;

    cpu_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr), .alu_result(alu_result), .alu_flags(alu_flags),
        .src2_data(src2_data), .flags(flags), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 Clk = ~Clk;

    // Stub datapath
    function automatic logic [31:0] f_res(input logic [31:0] w);
        return {16'hA5C3, w[18:3]};
    endfunction
    function automatic logic [3:0] f_fl(input logic [31:0] w);
        return w[10:7];
    endfunction
    function automatic logic [31:0] f_src2(input logic [31:0] w);
        return ~w ^ 32'h1234_5678;
    endfunction

    assign alu_result = f_res(instr);
    assign alu_flags  = f_fl(instr);
    assign src2_data  = f_src2(instr);

    // Bench RAM with wait states
    logic [31:0] ram [16];
    int lat_rd = 0, lat_wr = 0, wcnt = 0, cyc = 0;
    assign mem_ack   = mem_en && (wcnt >= (mem_rw ? lat_rd : lat_wr));
    assign mem_rdata = ram[mem_addr];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (mem_en && !mem_ack) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
    end

    // Observed event logs
    int rf_c[$], rd_c[$], rd_a[$], wr_c[$], wr_a[$];
    logic [31:0] rf_d[$], wr_d[$];
    always @(negedge Clk) begin
        if (rf_we) begin rf_c.push_back(cyc); rf_d.push_back(rf_wdata); end
        if (mem_en && mem_ack && mem_rw) begin rd_c.push_back(cyc); rd_a.push_back(int'(mem_addr)); end
        if (mem_en && !mem_rw) begin
            wr_c.push_back(cyc); wr_a.push_back(int'(mem_addr)); wr_d.push_back(mem_wdata);
        end
    end

    // Expected event logs (relative cycles from the first FETCH cycle)
    int e_rf_c[$], e_rd_c[$], e_rd_a[$], e_wr_c[$], e_wr_a[$];
    logic [31:0] e_rf_d[$], e_wr_d[$];
    int e_hc, e_pc;
    logic [3:0] e_fl;

    int errors = 0, checks = 0, run_base = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Conditions come in true/inverted pairs: bit 0 inverts the base test
    function automatic bit cpass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return b ^ c[0];
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] o,
                                       input logic s, input logic [22:0] low);
        return {c, o, s, low};
    endfunction

    // Instruction-level walk. With wrap set, pc 0 reads as HALT once pc 15
    // has been visited (the bench patches RAM[0] at that point).
    task automatic run_model(input int lr, input int lw, input bit wrap);
        int p, t;
        bit h, seen15;
        logic [31:0] w, res;
        logic [3:0] fl;
        e_rf_c.delete(); e_rf_d.delete(); e_rd_c.delete(); e_rd_a.delete();
        e_wr_c.delete(); e_wr_a.delete(); e_wr_d.delete();
        p = 0; t = 0; h = 0; seen15 = 0; fl = 4'h0; e_hc = -1;
        for (int s = 0; s < 64 && !h; s++) begin
            w = (wrap && seen15 && p == 0) ? HALT_W : ram[p];
            if (p == 15) seen15 = 1;
            e_rd_c.push_back(t + lr); e_rd_a.push_back(p);
            if (w[27:24] == 4'hF) begin
                e_hc = t + lr + 2; h = 1;
            end else if (!cpass(w[31:28], fl)) begin
                p = (p + 1) % 16; t += lr + 2;
            end else begin
                res = f_res(w);
                if (w[23]) fl = f_fl(w);
                case (w[27:24])
                    4'hD: begin
                        e_rd_c.push_back(t + 2*lr + 3); e_rd_a.push_back(int'(res[3:0]));
                        e_rf_c.push_back(t + 2*lr + 4); e_rf_d.push_back(ram[res[3:0]]);
                        t += 2*lr + 5;
                    end
                    4'hE: begin
                        for (int k = 0; k <= lw; k++) begin
                            e_wr_c.push_back(t + lr + 3 + k); e_wr_a.push_back(int'(res[3:0]));
                            e_wr_d.push_back(f_src2(w));
                        end
                        t += lr + lw + 4;
                    end
                    4'hA: t += lr + 3;
                    default: begin
                        e_rf_c.push_back(t + lr + 3); e_rf_d.push_back(res);
                        t += lr + 4;
                    end
                endcase
                p = (p + 1) % 16;
            end
        end
        e_pc = p; e_fl = fl;
    endtask

    task automatic run_prog(input int lr, input int lw, input bit wrap);
        int n_rf, n_rd, n_wr;
        bit patched, done;
        run_model(lr, lw, wrap);
        lat_rd = lr; lat_wr = lw;
        n_rf = rf_c.size(); n_rd = rd_c.size(); n_wr = wr_c.size();
        start = 1'b1; tick(); start = 1'b0;
        run_base = cyc;
        chk("first_fetch_en", mem_en, 1'b1);
        chk("first_fetch_rw", mem_rw, 1'b1);
        chk("first_fetch_addr", mem_addr, 0);
        chk("start_flags_clear", flags, 4'h0);
        chk("busy_running", busy, 1'b1);
        patched = 0; done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            start = (k == 3);   // must be ignored while busy
            if (wrap && !patched && pc == 4'd15) begin ram[0] = HALT_W; patched = 1; end
            if (halted) done = 1;
            else tick();
        end
        start = 1'b0;
        chk("halt_reached", done, 1'b1);
        chk("halt_cycle", cyc - run_base, e_hc);
        chk("halt_pc", pc, e_pc);
        chk("halt_flags", flags, e_fl);
        chk("halt_busy", busy, 1'b0);
        chk("rf_count", rf_c.size() - n_rf, e_rf_c.size());
        for (int i = 0; i < e_rf_c.size() && n_rf + i < rf_c.size(); i++) begin
            chk("rf_cycle", rf_c[n_rf+i] - run_base, e_rf_c[i]);
            chk("rf_data", rf_d[n_rf+i], e_rf_d[i]);
        end
        chk("rd_count", rd_c.size() - n_rd, e_rd_c.size());
        for (int i = 0; i < e_rd_c.size() && n_rd + i < rd_c.size(); i++) begin
            chk("rd_cycle", rd_c[n_rd+i] - run_base, e_rd_c[i]);
            chk("rd_addr", rd_a[n_rd+i], e_rd_a[i]);
        end
        chk("wr_count", wr_c.size() - n_wr, e_wr_c.size());
        for (int i = 0; i < e_wr_c.size() && n_wr + i < wr_c.size(); i++) begin
            chk("wr_cycle", wr_c[n_wr+i] - run_base, e_wr_c[i]);
            chk("wr_addr", wr_a[n_wr+i], e_wr_a[i]);
            chk("wr_data", wr_d[n_wr+i], e_wr_d[i]);
        end
    endtask

    initial begin
        int d_rf, d_wr;
        bit found;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        Reset = 1'b1;
        tick(); tick();
        chk("idle_no_fetch", mem_en, 1'b0);

        // Directed program: ALU, CMP(S) -> Z, EQ taken, NE skipped, LDR, STR, HALT
        ram[0] = mk(4'hE, 4'h4, 1'b0, 23'h01234);
        ram[1] = mk(4'hE, 4'hA, 1'b1, 23'h00200);
        ram[2] = mk(4'h0, 4'h0, 1'b0, 23'h00055);
        ram[3] = mk(4'h1, 4'h1, 1'b0, 23'h00066);
        ram[4] = mk(4'hE, 4'hD, 1'b0, 23'h00038);
        ram[5] = mk(4'hE, 4'hE, 1'b0, 23'h00048);
        ram[6] = HALT_W;
        ram[7] = 32'hDEAD_BEEF;
        d_rf = rf_c.size(); d_wr = wr_c.size();
        run_prog(0, 3, 1'b0);
        chk("dir_first_wb_latency", (rf_c.size() > d_rf) ? rf_c[d_rf] - run_base : -1, 3);
        chk("dir_ldr_data", (rf_c.size() > d_rf + 2) ? rf_d[d_rf+2] : 32'h0, 32'hDEAD_BEEF);
        chk("dir_str_hold_cycles", wr_c.size() - d_wr, 4);
        chk("dir_flags", flags, 4'b0100);
        chk("dir_halt_pc", pc, 6);
        chk("dir_halted", halted, 1'b1);

        // Random programs that wrap 15 -> 0 and halt on the patched RAM[0]
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < 15; a++) begin
                w = $urandom;
                w[27:24] = 4'($urandom_range(0, 14));
                ram[a] = w;
            end
            w = $urandom;
            w[31:24] = 8'hE3;
            ram[15] = w;
            run_prog(it, int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of a stalled store
        ram[0] = mk(4'hE, 4'hA, 1'b1, 23'h00200);
        ram[1] = mk(4'hE, 4'hE, 1'b0, 23'h00048);
        ram[2] = HALT_W;
        lat_rd = 0; lat_wr = 8;
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (mem_en && !mem_rw) found = 1;
            else tick();
        end
        chk("mid_mem_reached", found, 1'b1);
        tick(); tick();
        chk("mid_mem_flags", flags, 4'b0100);
        Reset = 1'b0; tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_mem_en", mem_en, 1'b0);
        chk("mrst_mem_rw", mem_rw, 1'b1);
        chk("mrst_pc", pc, 0);
        chk("mrst_flags", flags, 4'h0);
        chk("mrst_instr", instr, 32'h0);
        Reset = 1'b1;
        tick(); tick(); tick();
        chk("mrst_stays_idle", mem_en, 1'b0);
        chk("mrst_not_halted", halted, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
